// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl
//   Sequencer for the 2x2 max-pool engine. For each channel of a layer it
//   streams the feature map from the source buffer into the engine, one pixel
//   per cycle in raster order. It then captures the engine's pooled results
//   and writes them to the destination buffer. The channel count, map size
//   and buffer addressing are fixed by parameters.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             layer start pulse (honoured only while idle)
//   i_src_base/dst_base buffer base addresses, latched on an accepted start
//   o_busy              high whenever a layer is in progress
//   o_done              one-cycle pulse when the last channel completes
//   o_err               sticky output-count mismatch, cleared on start
//   o_rd_en/o_rd_addr   source buffer read port (data returns next cycle
//   i_rd_data           on i_rd_data)
//   o_pool_start        engine start pulse, one per channel
//   o_pool_data         pixel to the engine (zero when no read data is due)
//   i_pool_data/valid   pooled result from the engine
//   i_pool_done         engine finished the current map
//   o_wr_en/addr/data   destination buffer write port
module maxpool_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 6,
  parameter int IMG_HEIGHT = 6,
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src_base,
  input  logic [ADDR_WIDTH-1:0] i_dst_base,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_pool_start,
  output logic [DATA_WIDTH-1:0] o_pool_data,
  input  logic [DATA_WIDTH-1:0] i_pool_data,
  input  logic                  i_pool_valid,
  input  logic                  i_pool_done,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data
);

  localparam int PIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int OPIX = (IMG_WIDTH / 2) * (IMG_HEIGHT / 2);
  localparam int RC_W = $clog2(PIX + 1);
  localparam int WC_W = $clog2(OPIX + 1);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [RC_W-1:0]       RD_LAST   = RC_W'(PIX - 1);
  localparam logic [WC_W-1:0]       WR_FULL   = WC_W'(OPIX);
  localparam logic [CH_W-1:0]       CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [ADDR_WIDTH-1:0] RD_STRIDE = ADDR_WIDTH'(PIX);
  localparam logic [ADDR_WIDTH-1:0] WR_STRIDE = ADDR_WIDTH'(OPIX);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STREAM,
    ST_DRAIN,
    ST_NEXT
  } state_t;

  state_t                  state_reg, state_next;
  logic [CH_W-1:0]         ch_reg, ch_next;
  logic [RC_W-1:0]         rd_cnt_reg, rd_cnt_next;
  logic [WC_W-1:0]         wr_cnt_reg, wr_cnt_next;
  logic                    rd_vld_reg;
  logic [ADDR_WIDTH-1:0]   src_base_reg, src_base_next;
  logic [ADDR_WIDTH-1:0]   dst_base_reg, dst_base_next;
  // Per-channel address offsets (ch*PIX and ch*OPIX), kept as running sums
  // so no multiplier is needed in the address path.
  logic [ADDR_WIDTH-1:0]   rd_off_reg, rd_off_next;
  logic [ADDR_WIDTH-1:0]   wr_off_reg, wr_off_next;
  logic                    err_reg, err_next;
  logic                    wr_en_reg, wr_en_next;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg, wr_addr_next;
  logic [DATA_WIDTH-1:0]   wr_data_reg, wr_data_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      ch_reg       <= '0;
      rd_cnt_reg   <= '0;
      wr_cnt_reg   <= '0;
      rd_vld_reg   <= 1'b0;
      src_base_reg <= '0;
      dst_base_reg <= '0;
      rd_off_reg   <= '0;
      wr_off_reg   <= '0;
      err_reg      <= 1'b0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      ch_reg       <= ch_next;
      rd_cnt_reg   <= rd_cnt_next;
      wr_cnt_reg   <= wr_cnt_next;
      rd_vld_reg   <= o_rd_en;
      src_base_reg <= src_base_next;
      dst_base_reg <= dst_base_next;
      rd_off_reg   <= rd_off_next;
      wr_off_reg   <= wr_off_next;
      err_reg      <= err_next;
      wr_en_reg    <= wr_en_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ch_next       = ch_reg;
    rd_cnt_next   = rd_cnt_reg;
    wr_cnt_next   = wr_cnt_reg;
    src_base_next = src_base_reg;
    dst_base_next = dst_base_reg;
    rd_off_next   = rd_off_reg;
    wr_off_next   = wr_off_reg;
    err_next      = err_reg;
    wr_en_next    = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    o_rd_en       = 1'b0;
    o_pool_start  = 1'b0;
    o_done        = 1'b0;

    // Result capture runs in every active state. The write slot and its
    // address are claimed here, in the valid cycle, so a valid arriving
    // together with i_pool_done is already counted when NEXT checks wr_cnt.
    // The write itself lands one cycle later, whatever the state is then.
    if ((state_reg != ST_IDLE) && i_pool_valid) begin
      if (wr_cnt_reg != WR_FULL) begin
        wr_en_next   = 1'b1;
        wr_data_next = i_pool_data;
        wr_addr_next = dst_base_reg + wr_off_reg + ADDR_WIDTH'(wr_cnt_reg);
        wr_cnt_next  = wr_cnt_reg + WC_W'(1);
      end else begin
        // More results than the map can produce: drop and flag.
        err_next = 1'b1;
      end
    end

    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          src_base_next = i_src_base;
          dst_base_next = i_dst_base;
          ch_next       = '0;
          rd_cnt_next   = '0;
          wr_cnt_next   = '0;
          rd_off_next   = '0;
          wr_off_next   = '0;
          err_next      = 1'b0;
          state_next    = ST_START;
        end
      end
      ST_START: begin
        o_pool_start = 1'b1;
        o_rd_en      = 1'b1;
        rd_cnt_next  = RC_W'(1);
        state_next   = ST_STREAM;
      end
      ST_STREAM: begin
        o_rd_en     = 1'b1;
        rd_cnt_next = rd_cnt_reg + RC_W'(1);
        if (rd_cnt_reg == RD_LAST) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_pool_done) begin
          state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (wr_cnt_reg != WR_FULL) begin
          err_next = 1'b1;
        end
        wr_cnt_next = '0;
        rd_cnt_next = '0;
        if (ch_reg == CH_LAST) begin
          o_done     = 1'b1;
          state_next = ST_IDLE;
        end else begin
          ch_next     = ch_reg + CH_W'(1);
          rd_off_next = rd_off_reg + RD_STRIDE;
          wr_off_next = wr_off_reg + WR_STRIDE;
          state_next  = ST_START;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_busy      = (state_reg != ST_IDLE);
  assign o_err       = err_reg;
  assign o_rd_addr   = src_base_reg + rd_off_reg + ADDR_WIDTH'(rd_cnt_reg);
  // Only forward memory data in the cycle after a read was issued; the
  // engine sees zeros otherwise.
  assign o_pool_data = rd_vld_reg ? i_rd_data : '0;
  assign o_wr_en     = wr_en_reg;
  assign o_wr_addr   = wr_addr_reg;
  assign o_wr_data   = wr_data_reg;

endmodule

// File: doc/maxpool_ctrl.md
# maxpool_ctrl

Sequencer for the 2x2 max-pool engine. It streams a multi-channel feature map from a source buffer memory into the engine, one pixel per cycle in raster order. It captures the engine's pooled outputs and writes them to a destination buffer with computed addresses. It sits between the layer-level controller, which issues one start per layer, and the pooling engine plus its two buffer memories.

## Interface
Parameters:
- DATA_WIDTH, 16, pixel width (fixed point).
- IMG_WIDTH, 6, input map width, even.
- IMG_HEIGHT, 6, input map height, even.
- NUM_CH, 4, channels per layer, ≥1.
- ADDR_WIDTH, 12, buffer address width.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  reset; synchronous, active-high.
- i_start  in  1  layer start pulse; sampled only in IDLE.
- i_src_base  in  ADDR_WIDTH  source buffer base; latched on accepted start.
- i_dst_base  in  ADDR_WIDTH  destination buffer base; latched on accepted start.
- o_busy  out  1  high whenever state ≠ IDLE.
- o_done  out  1  one-cycle pulse when the last channel completes.
- o_err  out  1  sticky output-count mismatch flag; cleared on accepted start.
- o_rd_en  out  1  source read strobe.
- o_rd_addr  out  ADDR_WIDTH  source read address.
- i_rd_data  in  DATA_WIDTH  source read data, valid one cycle after o_rd_en.
- o_pool_start  out  1  engine start pulse.
- o_pool_data  out  DATA_WIDTH  pixel to engine.
- i_pool_data  in  DATA_WIDTH  pooled result from engine.
- i_pool_valid  in  1  i_pool_data valid this cycle.
- i_pool_done  in  1  engine finished the current map.
- o_wr_en  out  1  destination write strobe.
- o_wr_addr  out  ADDR_WIDTH  destination write address.
- o_wr_data  out  DATA_WIDTH  destination write data.

## Operation
- Constants:
  - PIX = IMG_WIDTH*IMG_HEIGHT.
  - OPIX = (IMG_WIDTH/2)*(IMG_HEIGHT/2).
- Registers:
  - ch: channel counter, 0..NUM_CH-1.
  - rd_cnt: pixel read counter, 0..PIX-1.
  - wr_cnt: per-channel output counter.
  - rd_vld: o_rd_en delayed one cycle.
  - src_base, dst_base: latched base addresses.
- Address arithmetic, modulo 2^ADDR_WIDTH (wrap-around allowed, no error):
  - o_rd_addr = src_base + ch*PIX + rd_cnt.
  - o_wr_addr = dst_base + ch*OPIX + wr_cnt.
- o_pool_data = rd_vld ? i_rd_data : 0. This output is combinational from the memory output.
- States:
  - IDLE: i_start → START. Latch both bases; clear ch and o_err.
  - START: assert o_pool_start and o_rd_en with rd_cnt=0; set rd_cnt=1 → STREAM.
  - STREAM: assert o_rd_en each cycle and increment rd_cnt. On the cycle rd_cnt==PIX-1 is issued → DRAIN.
  - DRAIN: no reads; o_pool_data is 0 once rd_vld falls. On i_pool_done → NEXT.
  - NEXT: if wr_cnt ≠ OPIX, set o_err. Clear wr_cnt and rd_cnt. If ch==NUM_CH-1 → IDLE with o_done=1; otherwise increment ch → START.
- Output capture, in any non-IDLE state: i_pool_valid registers i_pool_data into o_wr_data. o_wr_en=1 on the next cycle at the current wr_cnt address, then wr_cnt increments.
- i_pool_valid in the same cycle as i_pool_done is captured before the NEXT check.
- A write pending from the last valid completes even if the state has left DRAIN.
- wr_cnt saturates at OPIX. Extra valids beyond OPIX are not written and set o_err.
- i_start outside IDLE is ignored. i_pool_done outside DRAIN is ignored.
- Reset at any time returns to IDLE next edge. The engine is not reset by this block. Its own reset must accompany i_rst.

## Timing
- Reset values: o_busy=0, o_done=0, o_err=0, o_rd_en=0, o_rd_addr=src_base(0)+0, o_pool_start=0, o_pool_data=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0.
- Start sequence (i_start high at cycle 0 in IDLE):
  - Cycle 1: START; o_pool_start=1; read of pixel 0.
  - Cycles 1..PIX: o_rd_en=1.
  - Cycles 2..PIX+1: pixel k is on o_pool_data at cycle 2+k, i.e. one cycle after o_pool_start.
- Output write latency: one cycle from i_pool_valid to o_wr_en.
- Channel gap: done seen at cycle d → NEXT at d+1 → START of next channel at d+2.
- o_done is asserted in the NEXT cycle; o_busy falls on the following cycle.
- Throughput: the stream is back-to-back, one pixel per cycle, with no bubbles within a channel.

## Test plan
- W=H=6, NUM_CH=1, src=0x100, dst=0x200, behavioral engine model:
  - Expect 36 reads at 0x100..0x123 on consecutive cycles 1..36.
  - Expect 9 writes at 0x200..0x208 matching a reference pool of the input data.
  - Expect one o_done pulse and o_err=0.
- NUM_CH=2, same bases:
  - Expect channel 1 reads at 0x124..0x147 and writes at 0x209..0x211.
  - Expect exactly one o_done, after the 18th write.
- Engine model asserts done after only 8 valids:
  - Expect o_err=1 after NEXT.
  - Expect o_err cleared on the next accepted start.
- Pulse i_start during STREAM and i_pool_done during STREAM:
  - Expect no restart and no early NEXT; read sequence unchanged.
- src=0xFF0 with ADDR_WIDTH=12:
  - Expect read addresses to wrap 0xFFF → 0x000 without error.
- Assert i_rst in DRAIN of channel 0, then start again:
  - After reset, all outputs are at reset values and o_busy=0 on the next cycle.
  - A fresh start runs cleanly from channel 0.
